// File: rtl/ctl_pkg.sv
// ctl_pkg: shared definitions for the stopwatch control FSM.
//   state_t       - state encoding (2'b11 is unused and decodes as IDLE)
//   ctl_out_t     - {init_regs, count_enabled} output pair
//   OUT_*         - output decode constant for each state
//   decode_state  - maps a state to its output pair
package ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_COUNTING = 2'b01,
    ST_PAUSED   = 2'b10
  } state_t;

  typedef struct packed {
    logic init_regs;
    logic count_enabled;
  } ctl_out_t;

  localparam ctl_out_t OUT_IDLE     = '{init_regs: 1'b1, count_enabled: 1'b0};
  localparam ctl_out_t OUT_COUNTING = '{init_regs: 1'b0, count_enabled: 1'b1};
  localparam ctl_out_t OUT_PAUSED   = '{init_regs: 1'b0, count_enabled: 1'b0};

  function automatic ctl_out_t decode_state(input state_t st);
    case (st)
      ST_IDLE:     return OUT_IDLE;
      ST_COUNTING: return OUT_COUNTING;
      ST_PAUSED:   return OUT_PAUSED;
      default:     return OUT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ctl.sv
// ctl: stopwatch control FSM. Turns start/stop and clear button pulses into
// level controls for the counter/display datapath.
//   clk           in   system clock, rising edge
//   reset         in   async active-low reset
//   trig          in   start/stop request pulse
//   split         in   clear request pulse (acts only while paused)
//   init_regs     out  1 = hold datapath counters at zero
//   count_enabled out  1 = datapath counters advance
//
// state    | meaning
// ---------+----------------------------------------
// IDLE     | counters cleared, waiting for start
// COUNTING | counters running
// PAUSED   | counters frozen; trig resumes, split clears
module ctl
  import ctl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic trig,
  input  logic split,
  output logic init_regs,
  output logic count_enabled
);

  state_t   state_q;
  state_t   state_d;
  ctl_out_t out_dec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (trig) state_d = ST_COUNTING;
      end
      ST_COUNTING: begin
        if (trig) state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        // trig has priority over split when both arrive together
        if (trig)       state_d = ST_COUNTING;
        else if (split) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs depend on the registered state only, so no input-to-output path.
  always_comb begin
    out_dec       = decode_state(state_q);
    init_regs     = out_dec.init_regs;
    count_enabled = out_dec.count_enabled;
  end

endmodule

// File: tb/tb_ctl.sv
// tb_ctl: directed self-checking bench for the stopwatch control FSM.
module tb_ctl;

  logic clk;
  logic reset;
  logic trig;
  logic split;
  logic init_regs;
  logic count_enabled;

  int n_tests;
  int n_fail;

  ctl dut (
    .clk           (clk),
    .reset         (reset),
    .trig          (trig),
    .split         (split),
    .init_regs     (init_regs),
    .count_enabled (count_enabled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic exp_init, input logic exp_cnt);
    n_tests++;
    assert ({init_regs, count_enabled} === {exp_init, exp_cnt})
    else begin
      n_fail++;
      $error("FAIL %s: init_regs/count_enabled observed %b/%b expected %b/%b",
             tag, init_regs, count_enabled, exp_init, exp_cnt);
    end
  endtask

  // Drive inputs on the falling edge, let one rising edge sample them,
  // then check 1 time unit after that edge.
  task automatic step(input logic t, input logic s, input string tag,
                      input logic exp_init, input logic exp_cnt);
    @(negedge clk);
    trig  = t;
    split = s;
    @(posedge clk);
    #1;
    chk(tag, exp_init, exp_cnt);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    trig    = 1'b0;
    split   = 1'b0;

    // reset, before any clock edge
    #1;
    chk("reset_pre_clock", 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_held_2cyc", 1'b1, 1'b0);

    // trig during reset must be ignored
    @(negedge clk);
    trig = 1'b1;
    @(posedge clk);
    #1;
    chk("trig_during_reset", 1'b1, 1'b0);
    @(negedge clk);
    trig  = 1'b0;
    reset = 1'b1;

    step(1'b0, 1'b0, "idle_after_release", 1'b1, 1'b0);
    step(1'b0, 1'b1, "idle_split_ignored", 1'b1, 1'b0);

    // start / stop / resume
    step(1'b1, 1'b0, "trig1_counting", 1'b0, 1'b1);
    step(1'b0, 1'b0, "counting_hold", 1'b0, 1'b1);
    step(1'b1, 1'b0, "trig2_paused", 1'b0, 1'b0);
    step(1'b0, 1'b0, "paused_hold", 1'b0, 1'b0);
    step(1'b1, 1'b0, "trig3_counting", 1'b0, 1'b1);

    // split ignored while counting
    step(1'b0, 1'b1, "counting_split_1", 1'b0, 1'b1);
    step(1'b0, 1'b1, "counting_split_2", 1'b0, 1'b1);
    step(1'b0, 1'b1, "counting_split_3", 1'b0, 1'b1);

    // async reset while counting, between edges
    @(negedge clk);
    split = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_counting", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("reset_hold_edge", 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b0, "idle_after_async", 1'b1, 1'b0);

    // paused -> split clears
    step(1'b1, 1'b0, "p2_counting", 1'b0, 1'b1);
    step(1'b1, 1'b0, "p2_paused", 1'b0, 1'b0);
    step(1'b0, 1'b1, "paused_split_idle", 1'b1, 1'b0);

    // paused holds with no input
    step(1'b1, 1'b0, "p3_counting", 1'b0, 1'b1);
    step(1'b1, 1'b0, "p3_paused", 1'b0, 1'b0);
    step(1'b0, 1'b0, "paused_idle_in_1", 1'b0, 1'b0);
    step(1'b0, 1'b0, "paused_idle_in_2", 1'b0, 1'b0);

    // both inputs while paused: trig wins
    step(1'b1, 1'b1, "paused_both_trig_wins", 1'b0, 1'b1);

    // trig held high toggles every cycle
    step(1'b1, 1'b0, "held_trig_1", 1'b0, 1'b0);
    step(1'b1, 1'b0, "held_trig_2", 1'b0, 1'b1);
    step(1'b1, 1'b0, "held_trig_3", 1'b0, 1'b0);

    // async reset while paused
    @(negedge clk);
    trig = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_paused", 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b0, "idle_after_async2", 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
